// File: rtl/cu_pkg.sv
// Shared definitions for the sequenced control unit.
// Holds the opcode map, the ALU function-select codes, the decoder class-vector
// bit positions and the FSM state type.
package cu_pkg;

  // Opcode map.
  localparam int unsigned OP_NOP  = 0;
  localparam int unsigned OP_MOV  = 1;
  localparam int unsigned OP_MOVI = 2;
  localparam int unsigned OP_MVR0 = 3;
  localparam int unsigned OP_NOT  = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_XOR  = 7;
  localparam int unsigned OP_ADD  = 8;
  localparam int unsigned OP_SUB  = 9;
  localparam int unsigned OP_SHLL = 10;
  localparam int unsigned OP_SHRL = 11;
  localparam int unsigned OP_SHRA = 12;
  localparam int unsigned OP_JMP  = 13;
  localparam int unsigned OP_JZ   = 14;
  localparam int unsigned OP_HALT = 15;
  localparam int unsigned NUM_OPS = 16;

  // ALU select codes; 0 means pass-through (used by mov/mvr0).
  localparam int unsigned ALU_PASS = 0;
  localparam int unsigned ALU_NOT  = 1;
  localparam int unsigned ALU_AND  = 2;
  localparam int unsigned ALU_OR   = 3;
  localparam int unsigned ALU_XOR  = 4;
  localparam int unsigned ALU_ADD  = 5;
  localparam int unsigned ALU_SUB  = 6;
  localparam int unsigned ALU_SHLL = 7;
  localparam int unsigned ALU_SHRL = 8;
  localparam int unsigned ALU_SHRA = 9;

  // Bit positions in the decoder's one-hot class vector.
  localparam int unsigned CLS_NOP  = 0;
  localparam int unsigned CLS_ALU  = 1; // mov and all ALU ops
  localparam int unsigned CLS_MOVI = 2;
  localparam int unsigned CLS_MVR0 = 3;
  localparam int unsigned CLS_JMP  = 4;
  localparam int unsigned CLS_JZ   = 5;
  localparam int unsigned CLS_HALT = 6;
  localparam int unsigned CLS_ILL  = 7;
  localparam int unsigned NUM_CLS  = 8;

  typedef enum logic [2:0] {FETCH, DECODE, IMM, WB, EXEC, HALT} cu_state_e;

  // ALU opcodes are contiguous and map onto ALU_NOT..ALU_SHRA in order.
  function automatic int unsigned alu_code(input int unsigned op);
    return op - OP_NOT + ALU_NOT;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder.
// Ports:
//   op       - opcode field of the instruction register
//   op_class - one-hot instruction class (see CLS_* in cu_pkg)
//   alu_sel  - ALU function select for mov/ALU ops, 0 otherwise
//   illegal  - opcode is outside the defined map
module cu_decoder
  import cu_pkg::*;
#(
  parameter int unsigned OP_W      = 5,
  parameter int unsigned ALU_SEL_W = 4
) (
  input  logic [OP_W-1:0]      op,
  output logic [NUM_CLS-1:0]   op_class,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 illegal
);

  logic [31:0] op_val;

  always_comb begin
    op_val   = 32'(op);
    op_class = '0;
    alu_sel  = '0;
    if (op_val >= NUM_OPS) begin
      op_class[CLS_ILL] = 1'b1;
    end else if (op_val == OP_NOP) begin
      op_class[CLS_NOP] = 1'b1;
    end else if (op_val == OP_MOV) begin
      op_class[CLS_ALU] = 1'b1;
    end else if (op_val == OP_MOVI) begin
      op_class[CLS_MOVI] = 1'b1;
    end else if (op_val == OP_MVR0) begin
      op_class[CLS_MVR0] = 1'b1;
    end else if (op_val <= OP_SHRA) begin
      op_class[CLS_ALU] = 1'b1;
      alu_sel           = ALU_SEL_W'(alu_code(op_val));
    end else if (op_val == OP_JMP) begin
      op_class[CLS_JMP] = 1'b1;
    end else if (op_val == OP_JZ) begin
      op_class[CLS_JZ] = 1'b1;
    end else begin
      op_class[CLS_HALT] = 1'b1;
    end
  end

  assign illegal = op_class[CLS_ILL];

endmodule

// File: rtl/sequenced_control_unit.sv
// Multi-cycle control unit: fetches instruction words over a valid/ready
// handshake, owns the PC and sequences fetch/decode/execute.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   instValid/inst      - instruction memory word; instReady accepts it
//   pc                  - fetch address
//   regData, zeroFlag   - jump target and ALU zero flag from the datapath
//   aluSel, regInSel, regOutSel, regInEn, regOutEn - datapath controls
//   genConst/constOut   - drive the captured immediate onto the write bus
//   loadAddr            - PC loaded from regData this cycle
//   halted, illegal     - status: in HALT / undefined opcode pulse
module sequenced_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned INST_W    = 8,
  parameter int unsigned OP_W      = 5,
  parameter int unsigned REG_SEL_W = 3,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned ALU_SEL_W = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instValid,
  input  logic [INST_W-1:0]    inst,
  output logic                 instReady,
  output logic [ADDR_W-1:0]    pc,
  input  logic [ADDR_W-1:0]    regData,
  input  logic                 zeroFlag,
  output logic [ALU_SEL_W-1:0] aluSel,
  output logic [REG_SEL_W-1:0] regInSel,
  output logic [REG_SEL_W-1:0] regOutSel,
  output logic                 regInEn,
  output logic                 regOutEn,
  output logic                 genConst,
  output logic [INST_W-1:0]    constOut,
  output logic                 loadAddr,
  output logic                 halted,
  output logic                 illegal
);

  cu_state_e             state_q;
  logic [ADDR_W-1:0]     pc_q;
  logic [INST_W-1:0]     ir_q;
  logic [INST_W-1:0]     const_q;

  logic [NUM_CLS-1:0]    op_class;
  logic [ALU_SEL_W-1:0]  dec_alu_sel;
  logic                  dec_illegal;
  logic [REG_SEL_W-1:0]  ir_reg;
  logic                  take_jump;

  cu_decoder #(
    .OP_W      (OP_W),
    .ALU_SEL_W (ALU_SEL_W)
  ) u_decoder (
    .op       (ir_q[INST_W-1 -: OP_W]),
    .op_class (op_class),
    .alu_sel  (dec_alu_sel),
    .illegal  (dec_illegal)
  );

  assign ir_reg    = ir_q[REG_SEL_W-1:0];
  assign take_jump = op_class[CLS_JMP] | (op_class[CLS_JZ] & zeroFlag);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
      const_q <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (instValid) begin
            ir_q    <= inst;
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (op_class[CLS_NOP] || op_class[CLS_ILL]) state_q <= FETCH;
          else if (op_class[CLS_MOVI])                state_q <= IMM;
          else if (op_class[CLS_HALT])                state_q <= HALT;
          else                                        state_q <= EXEC;
        end
        IMM: begin
          if (instValid) begin
            const_q <= inst;
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= WB;
          end
        end
        WB: state_q <= FETCH;
        EXEC: begin
          if (take_jump) pc_q <= regData;
          state_q <= FETCH;
        end
        HALT: state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Outputs depend only on registered state/IR (plus zeroFlag for jz) and are
  // forced low while rst is asserted.
  always_comb begin
    instReady = 1'b0;
    aluSel    = '0;
    regInSel  = '0;
    regOutSel = '0;
    regInEn   = 1'b0;
    regOutEn  = 1'b0;
    genConst  = 1'b0;
    loadAddr  = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FETCH, IMM: instReady = 1'b1;
        DECODE:     illegal   = dec_illegal;
        WB: begin
          genConst = 1'b1;
          regInEn  = 1'b1;
        end
        EXEC: begin
          if (op_class[CLS_ALU]) begin
            regOutSel = ir_reg;
            regInEn   = 1'b1;
            regOutEn  = 1'b1;
            aluSel    = dec_alu_sel;
          end else if (op_class[CLS_MVR0]) begin
            regInSel = ir_reg;
            regInEn  = 1'b1;
            regOutEn = 1'b1;
          end else if (op_class[CLS_JMP] || op_class[CLS_JZ]) begin
            regOutSel = ir_reg;
            regOutEn  = 1'b1;
            loadAddr  = take_jump;
          end
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign pc       = pc_q;
  assign constOut = const_q;

endmodule
